tbird_lights_param: RTL

Parametrised tail-light sequencer: successor to the fixed 3-lamp T-bird FSM. Drives LAMPS lamps per side with left/right sweeping, hazard flashing, a programmable step prescaler, and a brake overlay. Sits between the driver-input synchroniser and the lamp drivers. Each clock-enable "tick" advances the sequence by one step.

---
 rtl/tbird_lights_param_if.sv | 24 ++
 rtl/tbird_lights_param.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/tbird_lights_param_if.sv
// rtl/tbird_lights_param_if.sv - driver-request and lamp-output bundle for the tail-light sequencer
interface tbird_lights_param_if #(
   parameter int LAMPS = 3
);
   logic             left;
   logic             right;
   logic             haz;
   logic             brake;
   logic [LAMPS-1:0] l_lights;
   logic [LAMPS-1:0] r_lights;
   logic             active;

   // Request side: the input synchroniser drives requests and may observe the lamps
   modport master (
      output left, right, haz, brake,
      input  l_lights, r_lights, active
   );

   // Sequencer side: consumes requests, drives the lamp bank
   modport slave (
      input  left, right, haz, brake,
      output l_lights, r_lights, active
   );
endinterface

// File: rtl/tbird_lights_param.sv
// rtl/tbird_lights_param.sv - parametrised tail-light sweep/hazard sequencer with brake overlay
module tbird_lights_param #(
   parameter int LAMPS = 3,
   parameter int DIV   = 1
) (
   input  logic                clk,
   input  logic                rst_b,
   tbird_lights_param_if.slave lights
);

   // rst_b is active-high despite its name: 1 holds the sequencer in reset.
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int PH_W  = $clog2(LAMPS + 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(LAMPS);

   // The sweeping side is held in mode; phase is the lit-lamp count k of Lk/Rk.
   typedef enum logic [1:0] {
      MODE_IDLE  = 2'd0,
      MODE_LEFT  = 2'd1,
      MODE_RIGHT = 2'd2,
      MODE_HAZ   = 2'd3
   } mode_t;

   logic [CNT_W-1:0] cnt;
   logic             tick;

   mode_t            mode;
   mode_t            mode_nxt;
   logic [PH_W-1:0]  phase;
   logic [PH_W-1:0]  phase_nxt;

   logic [LAMPS-1:0] therm;
   logic [LAMPS-1:0] l_base;
   logic [LAMPS-1:0] r_base;
   logic             l_free;
   logic             r_free;
   logic [LAMPS-1:0] l_out;
   logic [LAMPS-1:0] r_out;
   logic             act;

   // With DIV=1 the counter never leaves 0, so tick stays high every clock.
   assign tick = (cnt == CNT_LAST);

   // Free-running step prescaler: counts 0..DIV-1 and wraps on the tick
   always_ff @(posedge clk) begin
      if (rst_b) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // State register; reset wins over any pending tick
   always_ff @(posedge clk) begin
      if (rst_b) begin
         mode  <= MODE_IDLE;
         phase <= '0;
      end else begin
         mode  <= mode_nxt;
         phase <= phase_nxt;
      end
   end

   // Next-state logic: requests only matter on tick edges, otherwise hold
   always_comb begin
      mode_nxt  = mode;
      phase_nxt = phase;
      if (tick) begin
         unique case (mode)
            MODE_IDLE: begin
               // Both turn signals together are treated as a hazard request.
               if (lights.haz || (lights.left && lights.right)) begin
                  mode_nxt  = MODE_HAZ;
                  phase_nxt = '0;
               end else if (lights.left) begin
                  mode_nxt  = MODE_LEFT;
                  phase_nxt = PH_ONE;
               end else if (lights.right) begin
                  mode_nxt  = MODE_RIGHT;
                  phase_nxt = PH_ONE;
               end
            end
            MODE_LEFT, MODE_RIGHT: begin
               // The last lit step always falls to the off step; haz cannot
               // pre-empt it, and turn inputs are ignored for the whole sweep.
               if (phase == PH_LAST) begin
                  mode_nxt  = MODE_IDLE;
                  phase_nxt = '0;
               end else if (lights.haz) begin
                  mode_nxt  = MODE_HAZ;
                  phase_nxt = '0;
               end else begin
                  phase_nxt = phase + PH_ONE;
               end
            end
            MODE_HAZ: begin
               mode_nxt  = MODE_IDLE;
               phase_nxt = '0;
            end
            default: begin
               mode_nxt  = MODE_IDLE;
               phase_nxt = '0;
            end
         endcase
      end
   end

   // Output decode: Moore lamp pattern, then brake forces every non-sweeping side on
   always_comb begin
      therm  = '0;
      l_base = '0;
      r_base = '0;
      l_free = 1'b1;
      r_free = 1'b1;
      act    = 1'b0;
      for (int i = 0; i < LAMPS; i++) begin
         therm[i] = (i < int'(phase));
      end
      unique case (mode)
         MODE_LEFT: begin
            l_base = therm;
            l_free = 1'b0;
            act    = 1'b1;
         end
         MODE_RIGHT: begin
            r_base = therm;
            r_free = 1'b0;
            act    = 1'b1;
         end
         MODE_HAZ: begin
            l_base = '1;
            r_base = '1;
            act    = 1'b1;
         end
         default: begin
            act = 1'b0;
         end
      endcase
      l_out = l_base | {LAMPS{lights.brake & l_free}};
      r_out = r_base | {LAMPS{lights.brake & r_free}};
   end

   assign lights.l_lights = l_out;
   assign lights.r_lights = r_out;
   assign lights.active   = act;

endmodule
